// File: rtl/spi_burst_memory_if.sv
// rtl/spi_burst_memory_if.sv - SPI pin bundle between board master and memory slave
interface spi_burst_memory_if;
  logic sclk_pin;
  logic cs_pin;
  logic mosi_pin;
  logic miso_pin;
  logic miso_oe;

  modport master (output sclk_pin, cs_pin, mosi_pin, input miso_pin, miso_oe);
  modport slave  (input sclk_pin, cs_pin, mosi_pin, output miso_pin, miso_oe);
endinterface

// File: rtl/spi_burst_memory.sv
// rtl/spi_burst_memory.sv - SPI mode-0 slave RAM with command frames and auto-increment bursts
module spi_burst_memory #(
  parameter int ADDR_W      = 7,
  parameter int DATA_W      = 8,
  parameter int SYNC_STAGES = 2
) (
  input  logic              clk,
  input  logic              reset,
  spi_burst_memory_if.slave spi,
  output logic [DATA_W-1:0] last_wdata,
  output logic              busy
);
  localparam int SH_W  = (ADDR_W > DATA_W) ? ADDR_W : DATA_W;
  localparam int CNT_W = $clog2(SH_W + 2);

  localparam logic [2:0] IDLE        = 3'd0;
  localparam logic [2:0] GET_CMD     = 3'd1;
  localparam logic [2:0] READ_LOAD   = 3'd2;
  localparam logic [2:0] READ_SHIFT  = 3'd3;
  localparam logic [2:0] WRITE_SHIFT = 3'd4;

  logic [SYNC_STAGES-1:0] sclk_sync, cs_sync, mosi_sync;
  logic                   sclk_s, cs_s, mosi_s;
  logic                   sclk_d, cs_d;
  logic                   sclk_rise, sclk_fall, cs_fall;
  logic                   rise_ok, fall_ok;

  logic [2:0]        state;
  logic [CNT_W-1:0]  bit_cnt;
  logic [SH_W-1:0]   shreg;
  logic [DATA_W-1:0] out_sr;
  logic [ADDR_W-1:0] addr, addr_d;
  logic              wr_pend;
  logic              miso_q;

  logic [DATA_W-1:0] mem [2**ADDR_W];
  logic [DATA_W-1:0] rd_q;

  assign sclk_s = sclk_sync[SYNC_STAGES-1];
  assign cs_s   = cs_sync[SYNC_STAGES-1];
  assign mosi_s = mosi_sync[SYNC_STAGES-1];

  // Edge pulses are registered, so they land SYNC_STAGES+1 clocks after the pin edge.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sclk_sync <= '0;
      cs_sync   <= '1;
      mosi_sync <= '0;
      sclk_d    <= 1'b0;
      cs_d      <= 1'b1;
      sclk_rise <= 1'b0;
      sclk_fall <= 1'b0;
      cs_fall   <= 1'b0;
    end else begin
      sclk_sync <= {sclk_sync[SYNC_STAGES-2:0], spi.sclk_pin};
      cs_sync   <= {cs_sync[SYNC_STAGES-2:0], spi.cs_pin};
      mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], spi.mosi_pin};
      sclk_d    <= sclk_s;
      cs_d      <= cs_s;
      sclk_rise <= sclk_s & ~sclk_d;
      sclk_fall <= ~sclk_s & sclk_d;
      cs_fall   <= cs_d & ~cs_s;
    end
  end

  assign rise_ok = sclk_rise & ~cs_s;
  assign fall_ok = sclk_fall & ~cs_s;

  // The read port is addressed with the next address so READ_LOAD sees fresh data.
  always_comb begin
    addr_d = addr;
    if (wr_pend)
      addr_d = addr + ADDR_W'(1);
    else if (state == GET_CMD && rise_ok && bit_cnt == CNT_W'(ADDR_W))
      addr_d = shreg[ADDR_W-1:0];
    else if (state == READ_LOAD && !cs_s)
      addr_d = addr + ADDR_W'(1);
  end

  always_ff @(posedge clk) begin
    if (wr_pend)
      mem[addr] <= shreg[DATA_W-1:0];
    rd_q <= mem[addr_d];
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      bit_cnt    <= '0;
      shreg      <= '0;
      out_sr     <= '0;
      addr       <= '0;
      wr_pend    <= 1'b0;
      miso_q     <= 1'b0;
      last_wdata <= '0;
    end else begin
      addr <= addr_d;
      // A fully sampled word commits even if CS has already risen.
      if (wr_pend) begin
        last_wdata <= shreg[DATA_W-1:0];
        wr_pend    <= 1'b0;
        bit_cnt    <= '0;
      end
      if (cs_s && state != IDLE) begin
        state <= IDLE;
      end else begin
        case (state)
          IDLE: begin
            bit_cnt <= '0;
            if (cs_fall)
              state <= GET_CMD;
          end
          GET_CMD: begin
            if (rise_ok) begin
              shreg <= {shreg[SH_W-2:0], mosi_s};
              if (bit_cnt == CNT_W'(ADDR_W)) begin
                bit_cnt <= '0;
                state   <= mosi_s ? READ_LOAD : WRITE_SHIFT;
              end else begin
                bit_cnt <= bit_cnt + CNT_W'(1);
              end
            end
          end
          READ_LOAD: begin
            out_sr  <= rd_q;
            bit_cnt <= '0;
            state   <= READ_SHIFT;
          end
          READ_SHIFT: begin
            if (fall_ok) begin
              miso_q <= out_sr[DATA_W-1];
              out_sr <= {out_sr[DATA_W-2:0], 1'b0};
              if (bit_cnt == CNT_W'(DATA_W - 1))
                state <= READ_LOAD;
              else
                bit_cnt <= bit_cnt + CNT_W'(1);
            end
          end
          WRITE_SHIFT: begin
            if (rise_ok) begin
              shreg   <= {shreg[SH_W-2:0], mosi_s};
              bit_cnt <= bit_cnt + CNT_W'(1);
              if (bit_cnt == CNT_W'(DATA_W - 1))
                wr_pend <= 1'b1;
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

  assign spi.miso_pin = miso_q;
  assign spi.miso_oe  = (state == READ_LOAD || state == READ_SHIFT) && !cs_s;
  assign busy         = (state != IDLE);
endmodule

// File: tb/tb_spi_burst_memory.sv
// tb/tb_spi_burst_memory.sv - scoreboard bench for two spi_burst_memory configurations
module tb_spi_burst_memory;
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  logic sclk = 1'b0, mosi = 1'b0, cs_a = 1'b1, cs_b = 1'b1;
  spi_burst_memory_if ifa();
  spi_burst_memory_if ifb();
  assign ifa.sclk_pin = sclk;
  assign ifa.mosi_pin = mosi;
  assign ifa.cs_pin   = cs_a;
  assign ifb.sclk_pin = sclk;
  assign ifb.mosi_pin = mosi;
  assign ifb.cs_pin   = cs_b;

  logic [7:0]  lw_a;
  logic [15:0] lw_b;
  logic        busy_a, busy_b;

  spi_burst_memory #(.ADDR_W(7), .DATA_W(8), .SYNC_STAGES(2)) dut_a (
    .clk(clk), .reset(reset), .spi(ifa), .last_wdata(lw_a), .busy(busy_a));
  spi_burst_memory #(.ADDR_W(4), .DATA_W(16), .SYNC_STAGES(2)) dut_b (
    .clk(clk), .reset(reset), .spi(ifb), .last_wdata(lw_b), .busy(busy_b));

  int checks = 0;
  int errors = 0;
  int half = 6;

  logic [15:0] mem_a [128];
  logic [15:0] mem_b [16];
  logic [15:0] lw_model [2];
  logic [15:0] wq [$];
  logic [15:0] exp_q [$];

  bit rd_active = 1'b0;
  bit rd_sel = 1'b0;
  int rd_dw = 8;

  task automatic check(input string name, input logic [15:0] got, input logic [15:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s got %h want %h", name, got, want);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic send_bit(input bit b);
    mosi = b;
    cyc(half);
    sclk = 1'b1;
    cyc(half);
    sclk = 1'b0;
  endtask

  task automatic send_val(input int nb, input logic [31:0] v);
    for (int i = nb - 1; i >= 0; i--) send_bit(v[i]);
  endtask

  task automatic set_cs(input bit sel, input bit v);
    if (sel) cs_b = v; else cs_a = v;
  endtask

  function automatic logic [15:0] get_lw(input bit sel);
    return sel ? lw_b : {8'h00, lw_a};
  endfunction
  function automatic logic get_busy(input bit sel);
    return sel ? busy_b : busy_a;
  endfunction
  function automatic logic get_oe(input bit sel);
    return sel ? ifb.miso_oe : ifa.miso_oe;
  endfunction

  // Writes nw words popped from wq, then optionally partial extra bits before CS rises.
  task automatic write_frame(input bit sel, input int addr, input int nw, input int partial);
    int aw, dw, depth;
    logic [15:0] w;
    aw = sel ? 4 : 7;
    dw = sel ? 16 : 8;
    depth = 1 << aw;
    set_cs(sel, 1'b0);
    cyc(half);
    send_val(aw, addr);
    send_bit(1'b0);
    check("busy_in_write", {15'd0, get_busy(sel)}, 16'd1);
    check("oe_in_write", {15'd0, get_oe(sel)}, 16'd0);
    for (int k = 0; k < nw; k++) begin
      w = wq.pop_front();
      send_val(dw, w);
      if (sel) mem_b[(addr + k) % depth] = w; else mem_a[(addr + k) % depth] = w;
      lw_model[sel] = w;
    end
    if (partial > 0) send_val(partial, $urandom);
    cyc(half);
    set_cs(sel, 1'b1);
    cyc(12);
    check("last_wdata", get_lw(sel), lw_model[sel]);
    check("busy_after_write", {15'd0, get_busy(sel)}, 16'd0);
  endtask

  task automatic read_frame(input bit sel, input int addr, input int nw);
    int aw, dw, depth;
    aw = sel ? 4 : 7;
    dw = sel ? 16 : 8;
    depth = 1 << aw;
    for (int k = 0; k < nw; k++)
      exp_q.push_back(sel ? mem_b[(addr + k) % depth] : mem_a[(addr + k) % depth]);
    set_cs(sel, 1'b0);
    cyc(half);
    send_val(aw, addr);
    send_bit(1'b1);
    rd_sel = sel;
    rd_dw = dw;
    rd_active = 1'b1;
    send_val(nw * dw, 0);
    rd_active = 1'b0;
    cyc(half);
    set_cs(sel, 1'b1);
    cyc(12);
    check("oe_after_read", {15'd0, get_oe(sel)}, 16'd0);
    check("busy_after_read", {15'd0, get_busy(sel)}, 16'd0);
  endtask

  task automatic fill(input bit sel, input int depth, input int start);
    for (int k = 0; k < depth; k++) wq.push_back(sel ? 16'($urandom) : 16'($urandom_range(0, 255)));
    write_frame(sel, start, depth, 0);
  endtask

  // Monitor: samples MISO where a master would (SCLK rise) and scores completed words.
  initial begin
    int cnt;
    logic [15:0] acc;
    logic [15:0] e;
    cnt = 0;
    acc = '0;
    forever begin
      @(posedge sclk);
      if (rd_active) begin
        check("oe_during_read", {15'd0, get_oe(rd_sel)}, 16'd1);
        acc = {acc[14:0], rd_sel ? ifb.miso_pin : ifa.miso_pin};
        cnt++;
        if (cnt == rd_dw) begin
          if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_word got %h want none", acc);
          end else begin
            e = exp_q.pop_front();
            check("read_word", acc, e);
          end
          cnt = 0;
          acc = '0;
        end
      end else begin
        cnt = 0;
        acc = '0;
      end
    end
  end

  initial begin
    #3000000;
    $display("FAIL watchdog got timeout want finish");
    $fatal(1);
  end

  initial begin
    int a, n;
    bit s;
    reset = 1'b1;
    lw_model[0] = '0;
    lw_model[1] = '0;
    cyc(4);
    check("rst_miso_a", {15'd0, ifa.miso_pin}, 16'd0);
    check("rst_oe_a", {15'd0, ifa.miso_oe}, 16'd0);
    check("rst_busy_a", {15'd0, busy_a}, 16'd0);
    check("rst_lw_a", {8'd0, lw_a}, 16'd0);
    check("rst_lw_b", lw_b, 16'd0);
    reset = 1'b0;
    cyc(4);

    fill(1'b0, 128, 0);
    wq.push_back(16'h00A5);
    write_frame(1'b0, 'h15, 1, 0);
    read_frame(1'b0, 'h15, 1);

    wq.push_back(16'h0011); wq.push_back(16'h0022); wq.push_back(16'h0033);
    write_frame(1'b0, 'h7E, 3, 0);
    read_frame(1'b0, 'h7E, 3);

    wq.push_back(16'h003C);
    write_frame(1'b0, 'h05, 1, 0);
    wq.push_back(16'h005A);
    write_frame(1'b0, 'h40, 1, 0);
    write_frame(1'b0, 'h05, 0, 5);
    read_frame(1'b0, 'h05, 1);

    // Reset during the 4th bit of a read word
    set_cs(1'b0, 1'b0);
    cyc(half);
    send_val(7, 'h15);
    send_bit(1'b1);
    send_val(3, 0);
    mosi = 1'b0;
    cyc(half);
    sclk = 1'b1;
    cyc(2);
    reset = 1'b1;
    #1;
    check("rst_mid_oe", {15'd0, ifa.miso_oe}, 16'd0);
    check("rst_mid_busy", {15'd0, busy_a}, 16'd0);
    check("rst_mid_miso", {15'd0, ifa.miso_pin}, 16'd0);
    lw_model[0] = '0;
    lw_model[1] = '0;
    cyc(2);
    sclk = 1'b0;
    set_cs(1'b0, 1'b1);
    reset = 1'b0;
    cyc(12);
    read_frame(1'b0, 'h15, 2);

    fill(1'b1, 16, 3);
    wq.push_back(16'hBEEF);
    write_frame(1'b1, 'hF, 1, 0);
    read_frame(1'b1, 'hF, 1);
    read_frame(1'b1, 'hF, 2);

    for (int i = 0; i < 6; i++) begin
      s = 1'($urandom);
      half = $urandom_range(6, 8);
      a = $urandom_range(0, s ? 15 : 127);
      n = $urandom_range(1, 4);
      for (int k = 0; k < n; k++) wq.push_back(s ? 16'($urandom) : 16'($urandom_range(0, 255)));
      write_frame(s, a, n, 0);
      read_frame(s, $urandom_range(0, s ? 15 : 127), $urandom_range(1, 4));
    end

    cyc(20);
    check("scoreboard_empty", 16'(exp_q.size()), 16'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
